// File: rtl/fir_diff_symm.sv
// Streaming 10-tap antisymmetric FIR differentiator with pre-subtractor (5 multipliers).
// Q(8.6) in; Q(8.12) saturated and Q(8.6) rounded/saturated out over a 4-stage stall-able pipeline.
module fir_diff_symm #(
    parameter int DATA_WIDTH        = 14,
    parameter int FRACTIONAL_LENGTH = 6,
    parameter int PREDIFF_WL        = 15,
    parameter int SUM_WL            = 20,
    parameter int SUM_FL            = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [SUM_WL-1:0]     m_data_full,
    output logic                  m_sat,
    output logic                  primed
);

    localparam int ACC_WL = 23;
    localparam int RND_SH = SUM_FL - FRACTIONAL_LENGTH;

    localparam logic signed [7:0] A0 = 8'shFF;   // -1/64,   FL6
    localparam logic signed [8:0] A1 = 9'sh019;  // 25/128,  FL7
    localparam logic signed [8:0] A2 = 9'sh1CD;  // -51/128, FL7
    localparam logic signed [5:0] A3 = 6'sh07;   // 7/16,    FL4
    localparam logic signed [6:0] A4 = 7'sh13;   // 19/32,   FL5

    localparam logic signed [ACC_WL-1:0] FULL_MAX = 23'sd524287;
    localparam logic signed [ACC_WL-1:0] FULL_MIN = -23'sd524288;
    localparam logic signed [ACC_WL-1:0] RND_MAX  = 23'sd8191;
    localparam logic signed [ACC_WL-1:0] RND_MIN  = -23'sd8192;
    localparam logic signed [ACC_WL-1:0] RND_HALF = 23'sd32;

    logic en;
    logic accept;

    logic signed [DATA_WIDTH-1:0] line [9];
    logic signed [DATA_WIDTH-1:0] tap  [10];
    logic signed [PREDIFF_WL-1:0] dif_c [5];
    logic signed [PREDIFF_WL-1:0] dif_q [5];
    logic signed [ACC_WL-1:0]     prod_c [5];
    logic signed [ACC_WL-1:0]     prod_q [5];
    logic signed [ACC_WL-1:0]     acc_c, acc_q;
    logic signed [SUM_WL-1:0]     full_c, full_q;
    logic                         satf_c, satf_q;
    logic signed [ACC_WL-1:0]     rsum, rsh;
    logic signed [DATA_WIDTH-1:0] rnd_c;
    logic                         satr_c;
    logic                         v1, v2, v3;
    logic [3:0]                   count;

    logic signed [22:0] m0;
    logic signed [23:0] m1, m2;
    logic signed [20:0] m3;
    logic signed [21:0] m4;

    assign en      = !(m_valid && !m_ready);
    assign s_ready = en;
    assign accept  = s_valid && en;
    assign primed  = (count == 4'd10);

    // Stage 1 sees the incoming sample as x[n] and the stored line as x[n-1..n-9].
    always_comb begin
        tap[0] = s_data;
        for (int j = 1; j < 10; j++) tap[j] = line[j-1];
        for (int k = 0; k < 5; k++)
            dif_c[k] = PREDIFF_WL'(tap[k]) - PREDIFF_WL'(tap[9-k]);
    end

    // Products aligned to FL12: FL13 terms drop one LSB (floor), FL10/FL11 terms shift up.
    always_comb begin
        m0 = 23'(dif_q[0]) * 23'(A0);
        m1 = 24'(dif_q[1]) * 24'(A1);
        m2 = 24'(dif_q[2]) * 24'(A2);
        m3 = 21'(dif_q[3]) * 21'(A3);
        m4 = 22'(dif_q[4]) * 22'(A4);
        prod_c[0] = m0;
        prod_c[1] = m1[23:1];
        prod_c[2] = m2[23:1];
        prod_c[3] = {m3, 2'b00};
        prod_c[4] = {m4, 1'b0};
    end

    always_comb begin
        acc_c  = prod_q[0] + prod_q[1] + prod_q[2] + prod_q[3] + prod_q[4];
        satf_c = 1'b0;
        full_c = acc_c[SUM_WL-1:0];
        if (acc_c > FULL_MAX) begin
            full_c = {1'b0, {(SUM_WL-1){1'b1}}};
            satf_c = 1'b1;
        end else if (acc_c < FULL_MIN) begin
            full_c = {1'b1, {(SUM_WL-1){1'b0}}};
            satf_c = 1'b1;
        end
    end

    // Rounding works from the unsaturated sum so both outputs saturate independently.
    always_comb begin
        rsum   = acc_q + RND_HALF;
        rsh    = rsum >>> RND_SH;
        satr_c = 1'b0;
        rnd_c  = rsh[DATA_WIDTH-1:0];
        if (rsh > RND_MAX) begin
            rnd_c  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            satr_c = 1'b1;
        end else if (rsh < RND_MIN) begin
            rnd_c  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            satr_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 9; j++) line[j] <= '0;
            for (int k = 0; k < 5; k++) begin
                dif_q[k]  <= '0;
                prod_q[k] <= '0;
            end
            acc_q       <= '0;
            full_q      <= '0;
            satf_q      <= 1'b0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_data_full <= '0;
            m_sat       <= 1'b0;
            count       <= '0;
        end else begin
            if (accept) begin
                line[0] <= s_data;
                for (int j = 1; j < 9; j++) line[j] <= line[j-1];
                if (count != 4'd10) count <= count + 4'd1;
            end
            if (en) begin
                v1      <= accept;
                v2      <= v1;
                v3      <= v2;
                m_valid <= v3;
                if (accept) dif_q  <= dif_c;
                if (v1)     prod_q <= prod_c;
                if (v2) begin
                    acc_q  <= acc_c;
                    full_q <= full_c;
                    satf_q <= satf_c;
                end
                if (v3) begin
                    m_data      <= rnd_c;
                    m_data_full <= full_q;
                    m_sat       <= satf_q | satr_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_diff_symm.sv
// Bench for fir_diff_symm: impulse table, DC, saturation, backpressure, throughput and mid-stream reset.
// Expected outputs come from an integer model of the filter equation queued at input acceptance.
module tb_fir_diff_symm;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, m_valid, m_ready, m_sat, primed;
    logic [13:0] s_data, m_data;
    logic [19:0] m_data_full;

    always #5 clk = ~clk;

    fir_diff_symm dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_data_full(m_data_full),
        .m_sat      (m_sat),
        .primed     (primed)
    );

    typedef struct {
        logic [19:0] full;
        logic [13:0] data;
        logic        sat;
    } exp_t;

    typedef struct {
        logic [13:0] din;
        logic [19:0] exp_full;
        logic [13:0] exp_data;
    } vec_t;

    exp_t sbq[$];
    vec_t imp_tab[12];

    int checks = 0;
    int errors = 0;
    int hist[10];
    int mcount;
    int out_count = 0;
    int cyc = 0;
    int first_out_cyc;
    int stall_cnt = 0;
    int sat_cnt = 0;
    bit stall_prev = 0;
    logic [13:0] held_data;
    logic [19:0] held_full;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // y = sum a_k*(x[n-k]-x[n-9+k]) at FL12; FL13 products floored by >>>1.
    function automatic exp_t model_eval();
        exp_t e;
        int dd[5];
        int s, fc, r, rc;
        for (int k = 0; k < 5; k++) dd[k] = hist[k] - hist[9-k];
        s = -dd[0] + ((25 * dd[1]) >>> 1) + ((-51 * dd[2]) >>> 1) + 28 * dd[3] + 38 * dd[4];
        fc = clamp(s, -524288, 524287);
        r  = (s + 32) >>> 6;
        rc = clamp(r, -8192, 8191);
        e.full = 20'(fc);
        e.data = 14'(rc);
        e.sat  = (fc != s) || (rc != r);
        return e;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 10; j++) hist[j] = 0;
        mcount = 0;
        sbq.delete();
        stall_prev = 0;
    endtask

    task automatic model_accept(input logic [13:0] d, input bit push);
        for (int j = 9; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = int'($signed(d));
        mcount++;
        if (push) sbq.push_back(model_eval());
    endtask

    task automatic step(input logic v, input logic [13:0] d, input logic mr, output bit acc);
        exp_t e;
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        m_ready = mr;
        #1;
        cyc++;
        acc = 0;
        chk("primed", 32'(primed), 32'(mcount >= 10));
        if (m_valid && !m_ready) begin
            stall_cnt++;
            chk("s_ready_stall", 32'(s_ready), 32'(0));
            if (stall_prev) begin
                chk("hold_data", 32'(m_data), 32'(held_data));
                chk("hold_full", 32'(m_data_full), 32'(held_full));
            end
            held_data  = m_data;
            held_full  = m_data_full;
            stall_prev = 1;
        end else begin
            stall_prev = 0;
        end
        if (m_valid && m_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%0h required=none (cycle %0d)", m_data_full, cyc);
            end else begin
                e = sbq.pop_front();
                chk("m_data_full", 32'(m_data_full), 32'(e.full));
                chk("m_data", 32'(m_data), 32'(e.data));
                chk("m_sat", 32'(m_sat), 32'(e.sat));
                if (m_sat) sat_cnt++;
                out_count++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
            end
        end
        if (v && s_ready) acc = 1;
    endtask

    task automatic drive(input logic v, input logic [13:0] d, input logic mr);
        bit acc;
        step(v, d, mr, acc);
        if (acc) model_accept(d, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 60) begin
            drive(1'b0, 14'h0, 1'b1);
            n++;
        end
        chk("drain_left", 32'(sbq.size()), 32'(0));
        drive(1'b0, 14'h0, 1'b1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'(0));
        chk({tag, "_m_data"}, 32'(m_data), 32'(0));
        chk({tag, "_m_full"}, 32'(m_data_full), 32'(0));
        chk({tag, "_m_sat"}, 32'(m_sat), 32'(0));
        chk({tag, "_primed"}, 32'(primed), 32'(0));
        chk({tag, "_s_ready"}, 32'(s_ready), 32'(1));
    endtask

    task automatic run_impulse();
        bit acc;
        int acc_cyc;
        acc_cyc = 0;
        first_out_cyc = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, imp_tab[i].din, 1'b1, acc);
            chk("impulse_accept", 32'(acc), 32'(1));
            if (acc) begin
                if (i == 0) acc_cyc = cyc;
                model_accept(imp_tab[i].din, 0);
                sbq.push_back('{imp_tab[i].exp_full, imp_tab[i].exp_data, 1'b0});
            end
        end
        drain();
        chk("impulse_latency", 32'(first_out_cyc - acc_cyc), 32'(4));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [13:0] sat_pat [10];
        int base;

        imp_tab[0]  = '{14'h0040, 20'hFFFC0, 14'h3FFF};
        imp_tab[1]  = '{14'h0000, 20'h00320, 14'h000D};
        imp_tab[2]  = '{14'h0000, 20'hFF9A0, 14'h3FE7};
        imp_tab[3]  = '{14'h0000, 20'h00700, 14'h001C};
        imp_tab[4]  = '{14'h0000, 20'h00980, 14'h0026};
        imp_tab[5]  = '{14'h0000, 20'hFF680, 14'h3FDA};
        imp_tab[6]  = '{14'h0000, 20'hFF900, 14'h3FE4};
        imp_tab[7]  = '{14'h0000, 20'h00660, 14'h001A};
        imp_tab[8]  = '{14'h0000, 20'hFFCE0, 14'h3FF4};
        imp_tab[9]  = '{14'h0000, 20'h00040, 14'h0001};
        imp_tab[10] = '{14'h0000, 20'h00000, 14'h0000};
        imp_tab[11] = '{14'h0000, 20'h00000, 14'h0000};

        // Oldest first; every pre-difference takes the sign of its coefficient at full swing.
        sat_pat = '{14'h1FFF, 14'h2000, 14'h1FFF, 14'h2000, 14'h2000,
                    14'h1FFF, 14'h1FFF, 14'h2000, 14'h1FFF, 14'h2000};

        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("reset");

        run_impulse();

        for (int i = 0; i < 20; i++) drive(1'b1, 14'h0100, 1'b1);
        drain();

        for (int i = 0; i < 20; i++) drive(1'b1, (i % 2 == 0) ? 14'h1FFF : 14'h2000, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, sat_pat[i], 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, (sat_pat[i] == 14'h1FFF) ? 14'h2000 : 14'h1FFF, 1'b1);
        drain();
        chk("sat_seen", 32'(sat_cnt > 0), 32'(1));

        stall_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            logic v;
            v = (i >= 14 && i <= 19) ? 1'b1 : 1'($urandom_range(0, 1));
            drive(v, 14'($urandom), (i >= 20 && i <= 22) ? 1'b0 : 1'b1);
        end
        drain();
        chk("stall_cycles", 32'(stall_cnt), 32'(3));

        base = out_count;
        for (int i = 0; i < 100; i++) drive(1'b1, 14'($urandom), 1'b1);
        chk("throughput", 32'(out_count - base), 32'(96));
        drain();

        for (int i = 0; i < 5; i++) drive(1'b1, 14'($urandom), 1'b1);
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check_idle_outputs("midreset");

        run_impulse();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
